// File: rtl/pipe_accum_alu.sv
// rtl/pipe_accum_alu.sv - two-stage pipelined ADD/ACC/SUB/CLR unit with running accumulator and op counter
// Define PIPE_ACCUM_SATURATE_EN to clamp ACC/SUB results instead of wrapping; default build wraps.
module pipe_accum_alu #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_ACC = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [1:0]       s1_mode_q, s1_mode_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic             s2_can_load;
  logic             s2_load;
  logic             in_fire;

  logic [ACC_W-1:0] a_ext, b_ext;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] sub_diff;
  logic             borrow;
  logic [CNT_W-1:0] count_inc;

  logic [ACC_W-1:0] op_result;
  logic             op_ovf;
  logic [ACC_W-1:0] op_acc;
  logic [CNT_W-1:0] op_count;

  // in_ready depends on out_ready only, never on in_valid
  assign s2_can_load = !out_valid_q || out_ready;
  assign s2_load     = s1_valid_q && s2_can_load;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign in_fire     = in_valid && in_ready;

  assign a_ext     = {{(ACC_W-WIDTH){1'b0}}, s1_a_q};
  assign b_ext     = {{(ACC_W-WIDTH){1'b0}}, s1_b_q};
  assign acc_sum   = {1'b0, acc_q} + {1'b0, a_ext} + {1'b0, b_ext};
  assign sub_diff  = a_ext - b_ext;
  assign borrow    = s1_a_q < s1_b_q;
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    op_result = '0;
    op_ovf    = 1'b0;
    op_acc    = acc_q;
    op_count  = count_q;
    case (s1_mode_q)
      MODE_ADD: begin
        op_result = a_ext + b_ext;
      end
      MODE_ACC: begin
`ifdef PIPE_ACCUM_SATURATE_EN
        op_acc = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
        op_acc = acc_sum[ACC_W-1:0];
`endif
        op_result = op_acc;
        op_ovf    = acc_sum[ACC_W];
        op_count  = count_inc;
      end
      MODE_SUB: begin
`ifdef PIPE_ACCUM_SATURATE_EN
        op_result = borrow ? '0 : sub_diff;
`else
        op_result = sub_diff;
`endif
        op_ovf = borrow;
      end
      MODE_CLR: begin
        op_acc   = '0;
        op_count = '0;
      end
      default: begin
        op_result = '0;
      end
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_mode_d  = mode;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 holds everything stable while stalled; acc/count only move when a beat enters S2
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    acc_d       = acc_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      result_d    = op_result;
      ovf_d       = op_ovf;
      count_d     = op_count;
      acc_d       = op_acc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= MODE_ADD;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_accum_alu.sv
// tb/tb_pipe_accum_alu.sv - table vectors, directed stall/reset sequences and random stream vs reference model
// Expectations follow PIPE_ACCUM_SATURATE_EN when the bundle is built with it.
module tb_pipe_accum_alu;

  localparam int WIDTH   = 8;
  localparam int ACC_W   = 10;
  localparam int CNT_W   = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             ovf;
  logic [CNT_W-1:0] count;

  pipe_accum_alu #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int md;
    int va;
    int vb;
    int result;
    int ovf;
    int count;
  } vec_t;

  typedef struct {
    int result;
    int ovf;
    int count;
  } beat_t;

  beat_t exp_q[$];
  beat_t held;
  beat_t last_out;
  bit    hold_pending;
  bit    got_out;
  bit    saw_stall;
  int    n_out;
  int    m_acc;
  int    m_cnt;
  int    checks;
  int    errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: each beat's effect computed in acceptance order with plain integer arithmetic
  function automatic beat_t model(input int md, input int x, input int y);
    beat_t r;
    int s;
    r.result = 0;
    r.ovf    = 0;
    case (md)
      0: r.result = x + y;
      1: begin
        s = m_acc + x + y;
        if (s > ACC_MAX) begin
          r.ovf = 1;
          m_acc = SAT ? ACC_MAX : s - (ACC_MAX + 1);
        end else begin
          m_acc = s;
        end
        r.result = m_acc;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      2: begin
        r.ovf = (x < y) ? 1 : 0;
        if (x >= y) r.result = x - y;
        else        r.result = SAT ? 0 : x - y + ACC_MAX + 1;
      end
      default: begin
        m_acc = 0;
        m_cnt = 0;
      end
    endcase
    r.count = m_cnt;
    return r;
  endfunction

  // One cycle: sample at negedge+1, score transfers, then advance to the next negedge
  task automatic tick();
    beat_t e;
    got_out = 1'b0;
    #1;
    if (hold_pending) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_result", int'(result), held.result);
      chk("hold_ovf", int'(ovf), held.ovf);
      chk("hold_count", int'(count), held.count);
      hold_pending = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("beat_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_result", int'(result), e.result);
        chk("out_ovf", int'(ovf), e.ovf);
        chk("out_count", int'(count), e.count);
      end
      last_out.result = int'(result);
      last_out.ovf    = int'(ovf);
      last_out.count  = int'(count);
      got_out = 1'b1;
      n_out++;
    end
    if (out_valid && !out_ready) begin
      hold_pending  = 1'b1;
      held.result   = int'(result);
      held.ovf      = int'(ovf);
      held.count    = int'(count);
    end
    if (in_valid && in_ready) exp_q.push_back(model(int'(mode), int'(a), int'(b)));
    if (!in_ready) saw_stall = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    in_valid  = 1'b1;
    mode      = v.md[1:0];
    a         = v.va[WIDTH-1:0];
    b         = v.vb[WIDTH-1:0];
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      tick();
      if (got_out) break;
      lat++;
    end
    chk({name, "_latency"}, lat, 2);
    chk({name, "_result"}, last_out.result, v.result);
    chk({name, "_ovf"}, last_out.ovf, v.ovf);
    chk({name, "_count"}, last_out.count, v.count);
  endtask

  task automatic stream_acc1(input int nbeats, input int stall_lo, input int stall_hi);
    int sent;
    int cyc;
    sent  = 0;
    cyc   = 1;
    n_out = 0;
    while (n_out < nbeats && cyc < 200) begin
      in_valid  = (sent < nbeats);
      mode      = 2'b01;
      a         = 8'd1;
      b         = 8'd0;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_beats_out", n_out, nbeats);
  endtask

  vec_t vecs[13];
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;
    m_acc  = 0;
    m_cnt  = 0;
    hold_pending = 1'b0;
    saw_stall    = 1'b0;
    n_out        = 0;

    vecs[0]  = '{0, 200, 100, 300, 0, 0};
    vecs[1]  = '{1, 255, 255, 510, 0, 1};
    vecs[2]  = '{1, 255, 255, 1020, 0, 2};
    vecs[3]  = '{1, 255, 255, SAT ? 1023 : 506, 1, 3};
    vecs[4]  = '{1, 255, 255, SAT ? 1023 : 1016, SAT ? 1 : 0, 4};
    vecs[5]  = '{1, 255, 255, SAT ? 1023 : 502, 1, 5};
    vecs[6]  = '{2, 5, 9, SAT ? 0 : 1020, 1, 5};
    vecs[7]  = '{0, 255, 255, 510, 0, 5};
    vecs[8]  = '{3, 77, 33, 0, 0, 0};
    vecs[9]  = '{2, 9, 5, 4, 0, 0};
    vecs[10] = '{1, 10, 0, 10, 0, 1};
    vecs[11] = '{3, 0, 0, 0, 0, 0};
    vecs[12] = '{1, 3, 4, 7, 0, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = 2'b00;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset with two beats in flight
    in_valid  = 1'b1;
    mode      = 2'b01;
    a         = 8'd5;
    b         = 8'd5;
    out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    hold_pending = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_beat", int'(got_out), 0);
    end
    v = '{1, 1, 1, 2, 0, 1};
    run_vec("post_rst_acc", v);

    // Six ACC beats with a backpressure window
    v = '{3, 0, 0, 0, 0, 0};
    run_vec("stall_clr", v);
    saw_stall = 1'b0;
    stream_acc1(6, 3, 7);
    chk("stall_in_ready_low_seen", int'(saw_stall), 1);
    chk("stall_last_result", last_out.result, 6);
    chk("stall_last_count", last_out.count, 6);

    // Counter saturation
    v = '{3, 0, 0, 0, 0, 0};
    run_vec("sat_clr", v);
    stream_acc1(CNT_MAX + 3, 0, 0);
    chk("cnt_sat_count", last_out.count, CNT_MAX);
    chk("cnt_sat_result", last_out.result, CNT_MAX + 3);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      mode      = 2'($urandom_range(3));
      a         = 8'($urandom_range(255));
      b         = 8'($urandom_range(255));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk("drain_queue_empty", exp_q.size(), 0);
    tick();
    chk("drain_out_valid", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
